// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub: W-bit add/subtract built from one 4-bit ripple slice,
// processing one nibble per clock with the carry chained through a register.
// Operands arrive on a valid/ready handshake; results and flags are held until
// the consumer takes them.
// Optional feature: define SAT_EN to clamp S on signed overflow.
module nibble_serial_addsub #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic                 ctrl,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] S,
  output logic                 Cout,
  output logic                 V,
  output logic                 Z
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            ctrl_q;
  logic            carry_reg;
  logic [IW-1:0]   idx;

  logic [3:0]      nib_a;
  logic [3:0]      nib_b;
  logic [3:0]      nib_s;
  logic [4:0]      c;
  logic [W-1:0]    s_next;
  logic            last;
`ifdef SAT_EN
  logic [W-1:0]    sat_val;
`endif

  // Accepting only in IDLE and never while reset is asserted.
  assign in_ready = rst_n & (state == IDLE);
  assign last     = (idx == IW'(NIBBLES - 1));

  // 4-bit ripple slice on the current nibble; B is inverted for subtract.
  always_comb begin
    nib_a  = a_q[idx*4 +: 4];
    nib_b  = b_q[idx*4 +: 4] ^ {4{ctrl_q}};
    nib_s  = '0;
    c      = '0;
    c[0]   = carry_reg;
    for (int unsigned b = 0; b < 4; b++) begin
      nib_s[b]   = nib_a[b] ^ nib_b[b] ^ c[b];
      c[b+1]     = (nib_a[b] & nib_b[b]) | (nib_a[b] & c[b]) | (nib_b[b] & c[b]);
    end
    s_next = S;
    s_next[idx*4 +: 4] = nib_s;
  end

`ifdef SAT_EN
  // Clamp value follows the sign of the latched A operand.
  always_comb begin
    sat_val = a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end
`endif

  // Operation FSM: accept, run one nibble per cycle, hold result until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      S         <= '0;
      Cout      <= 1'b0;
      V         <= 1'b0;
      Z         <= 1'b0;
      out_valid <= 1'b0;
      carry_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q       <= A;
            b_q       <= B;
            ctrl_q    <= ctrl;
            idx       <= '0;
            carry_reg <= ctrl;
            state     <= RUN;
          end
        end
        RUN: begin
          S         <= s_next;
          carry_reg <= c[4];
          idx       <= idx + 1'b1;
          if (last) begin
            Cout      <= c[4];
            V         <= c[3] ^ c[4];
            Z         <= (s_next == '0);
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef SAT_EN
            // Later assignments override the wrapped S and its zero flag.
            if (c[3] ^ c[4]) begin
              S <= sat_val;
              Z <= 1'b0;
            end
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
